// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: opcodes, FSM states,
// instruction classes and error codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] CLS_R     = 4'd0;
    localparam logic [3:0] CLS_IALU  = 4'd1;
    localparam logic [3:0] CLS_LOAD  = 4'd2;
    localparam logic [3:0] CLS_STORE = 4'd3;
    localparam logic [3:0] CLS_BR    = 4'd4;
    localparam logic [3:0] CLS_JAL   = 4'd5;
    localparam logic [3:0] CLS_JALR  = 4'd6;
    localparam logic [3:0] CLS_LUI   = 4'd7;
    localparam logic [3:0] CLS_AUIPC = 4'd8;
    localparam logic [3:0] CLS_ILL   = 4'd15;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_IMEM_TMO = 2'b10;
    localparam logic [1:0] ERR_DMEM_TMO = 2'b11;

    // run is only looked at on an instruction boundary.
    function automatic state_e after_retire(input logic run);
        return run ? ST_FETCH : ST_IDLE;
    endfunction

endpackage

// File: rtl/mc_op_class.sv
// Combinational opcode classifier: 7-bit Op to 4-bit class plus illegal flag.
module mc_op_class
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [3:0] op_class,
    output logic       illegal
);

    // Map each legal opcode to its class; everything else is illegal.
    always_comb begin
        op_class = CLS_ILL;
        illegal  = 1'b1;
        case (op)
            OP_R:     begin op_class = CLS_R;     illegal = 1'b0; end
            OP_IALU:  begin op_class = CLS_IALU;  illegal = 1'b0; end
            OP_LOAD:  begin op_class = CLS_LOAD;  illegal = 1'b0; end
            OP_STORE: begin op_class = CLS_STORE; illegal = 1'b0; end
            OP_BR:    begin op_class = CLS_BR;    illegal = 1'b0; end
            OP_JAL:   begin op_class = CLS_JAL;   illegal = 1'b0; end
            OP_JALR:  begin op_class = CLS_JALR;  illegal = 1'b0; end
            OP_LUI:   begin op_class = CLS_LUI;   illegal = 1'b0; end
            OP_AUIPC: begin op_class = CLS_AUIPC; illegal = 1'b0; end
            default:  begin op_class = CLS_ILL;   illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with memory
// handshakes, write-enable pulses, timeout/illegal halt and retire counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TMO_CYC = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic [6:0]       Op,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       err_code
);

    localparam int WAIT_W = $clog2(TMO_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TMO_CYC - 1);

    state_e            state_r, state_s;
    logic [3:0]        class_r, class_s;
    logic [3:0]        dec_class_s;
    logic              dec_illegal_s;
    logic [WAIT_W-1:0] wait_r, wait_s;
    logic [CNT_W-1:0]  instret_r;
    logic              halted_r, halted_s;
    logic [1:0]        err_r, err_s;

    mc_op_class u_op_class (
        .op       (Op),
        .op_class (dec_class_s),
        .illegal  (dec_illegal_s)
    );

    // Next-state, wait-counter and handshake/enable decode.
    always_comb begin
        state_s  = state_r;
        class_s  = class_r;
        wait_s   = wait_r;
        halted_s = halted_r;
        err_s    = err_r;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        retire   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_s = ST_FETCH;
                    wait_s  = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_s = ST_DECODE;
                    wait_s  = '0;
                end else if (wait_r == WAIT_LAST) begin
                    state_s  = ST_HALT;
                    halted_s = 1'b1;
                    err_s    = ERR_IMEM_TMO;
                end else begin
                    wait_s = wait_r + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                class_s = dec_class_s;
                if (dec_illegal_s) begin
                    state_s  = ST_HALT;
                    halted_s = 1'b1;
                    err_s    = ERR_ILLEGAL;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_r)
                    CLS_BR: begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_s = after_retire(run);
                        wait_s  = '0;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        state_s = ST_MEM;
                        wait_s  = '0;
                    end
                    default: state_s = ST_WB;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (class_r == CLS_STORE);
                if (dmem_ready) begin
                    wait_s = '0;
                    if (class_r == CLS_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_s = after_retire(run);
                    end else begin
                        state_s = ST_WB;
                    end
                end else if (wait_r == WAIT_LAST) begin
                    state_s  = ST_HALT;
                    halted_s = 1'b1;
                    err_s    = ERR_DMEM_TMO;
                end else begin
                    wait_s = wait_r + WAIT_W'(1);
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_s = after_retire(run);
                wait_s  = '0;
            end
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM, class latch, wait counter and sticky error state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            class_r  <= CLS_R;
            wait_r   <= '0;
            halted_r <= 1'b0;
            err_r    <= ERR_NONE;
        end else begin
            state_r  <= state_s;
            class_r  <= class_s;
            wait_r   <= wait_s;
            halted_r <= halted_s;
            err_r    <= err_s;
        end
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instret_r <= '0;
        end else if (retire) begin
            instret_r <= instret_r + CNT_W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    assign instret  = instret_r;
    assign state    = state_r;
    assign halted   = halted_r;
    assign err_code = err_r;

endmodule
